// File: rtl/bf_pkg.sv
// Shared types and default widths for the VGA cell server.
package bf_pkg;

  localparam int CFS_ADDR_W = 15;
  localparam int CFS_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VGA_RD = 2'd1,
    CPU_RD = 2'd2,
    CPU_WR = 2'd3
  } cfs_state_t;

endpackage

// File: rtl/vga_cell_server.sv
// Arbitrates one single-port tape RAM between display cell fetches and CPU access.
// Optional VGA_CELL_SERVER_BYPASS_EN: a CPU write to the held cell updates vga_cell directly.
module vga_cell_server
  import bf_pkg::*;
#(
  parameter int ADDR_W = CFS_ADDR_W,
  parameter int DATA_W = CFS_DATA_W
) (
  input  logic              clk_pixel,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] vga_data_addr,
  input  logic              in_display_area,
  output logic [DATA_W-1:0] vga_cell,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  cfs_state_t        state, state_nx;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] fetch_addr;
  logic              vga_pend;

  assign vga_pend = in_display_area && (vga_data_addr != last_addr);

  always_comb begin
    state_nx  = state;
    ram_addr  = cpu_addr;
    ram_we    = 1'b0;
    ram_wdata = cpu_wdata;
    case (state)
      IDLE: begin
        if (vga_pend) begin
          ram_addr = vga_data_addr;
          state_nx = VGA_RD;
        end else if (cpu_req) begin
          // Write strobe gated by resetn so nothing is written while reset is held.
          ram_we   = cpu_we & resetn;
          state_nx = cpu_we ? CPU_WR : CPU_RD;
        end
      end
      VGA_RD:  state_nx = IDLE;
      CPU_RD:  state_nx = IDLE;
      CPU_WR:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      state      <= IDLE;
      vga_cell   <= '0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      last_addr  <= '1;
      fetch_addr <= '0;
    end else begin
      state   <= state_nx;
      cpu_ack <= 1'b0;
      if (state == IDLE && vga_pend)
        fetch_addr <= vga_data_addr;
      case (state)
        VGA_RD: begin
          vga_cell  <= ram_rdata;
          last_addr <= fetch_addr;
        end
        CPU_RD: begin
          cpu_rdata <= ram_rdata;
          cpu_ack   <= 1'b1;
        end
        CPU_WR: begin
          cpu_ack <= 1'b1;
`ifdef VGA_CELL_SERVER_BYPASS_EN
          if (cpu_addr == last_addr)
            vga_cell <= cpu_wdata;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
